fwd_hazard_ctrl: RTL and testbench

//  Producer side of execute-stage register forwarding. Tracks destination registers of in-flight

---
 rtl/y86_pkg.sv | 39 +++
 rtl/fwd_reg_match.sv | 27 ++
 rtl/fwd_hazard_ctrl.sv | 116 +++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// ============================================================================
//  Module   : y86_pkg
//  Purpose  : Shared register codes, pipeline entry type and match helper.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package y86_pkg;

    localparam int REG_W = 4;
    localparam logic [REG_W-1:0] RNONE = 4'hF;

    localparam logic [REG_W-1:0] REG_EAX = 4'd0;
    localparam logic [REG_W-1:0] REG_ECX = 4'd1;
    localparam logic [REG_W-1:0] REG_EDX = 4'd2;
    localparam logic [REG_W-1:0] REG_EBX = 4'd3;
    localparam logic [REG_W-1:0] REG_ESP = 4'd4;
    localparam logic [REG_W-1:0] REG_EBP = 4'd5;
    localparam logic [REG_W-1:0] REG_ESI = 4'd6;
    localparam logic [REG_W-1:0] REG_EDI = 4'd7;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dst_e;
        logic [REG_W-1:0] dst_m;
    } fwd_entry_t;

    localparam fwd_entry_t ENTRY_EMPTY = '{valid: 1'b0, dst_e: RNONE, dst_m: RNONE};

    // RNONE never matches, so unused sources can never forward or stall.
    function automatic logic reg_match(input logic [REG_W-1:0] src,
                                       input logic [REG_W-1:0] r,
                                       input logic             valid);
        return valid && (r != RNONE) && (src == r);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fwd_reg_match.sv
// ============================================================================
//  Module   : fwd_reg_match
//  Purpose  : Compares decode sources A/B against one in-flight entry.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_reg_match
    import y86_pkg::*;
(
    input  logic [REG_W-1:0] src_a,
    input  logic [REG_W-1:0] src_b,
    input  fwd_entry_t       entry,
    output logic             hit_e,
    output logic             hit_m
);

    always_comb begin
        hit_e = reg_match(src_a, entry.dst_e, entry.valid) |
                reg_match(src_b, entry.dst_e, entry.valid);
        hit_m = reg_match(src_a, entry.dst_m, entry.valid) |
                reg_match(src_b, entry.dst_m, entry.valid);
    end

endmodule

`default_nettype wire

// File: rtl/fwd_hazard_ctrl.sv
// ============================================================================
//  Module   : fwd_hazard_ctrl
//  Purpose  : Tracks EX/EX2/MEM destinations, issues forward flags and
//             load-use stalls for the instruction entering execute.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_hazard_ctrl
    import y86_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             hold,
    input  logic             flush,
    input  logic             dec_valid,
    input  logic [REG_W-1:0] dec_srcA,
    input  logic [REG_W-1:0] dec_srcB,
    input  logic [REG_W-1:0] dec_dstE,
    input  logic [REG_W-1:0] dec_dstM,
    output logic             stall_decode,
    output logic             ex_bubble,
    output logic             fwd_apply_ex2,
    output logic [1:0]       fwd_apply_mem,
    output logic [REG_W-1:0] fwd_ex2_reg,
    output logic [REG_W-1:0] fwd_mem_regA,
    output logic [REG_W-1:0] fwd_mem_regB,
    output logic [CNT_W-1:0] stall_count
);

    fwd_entry_t       ex_q, ex_d, ex2_q, ex2_d, mem_q, mem_d;
    logic             apply_ex2_q, apply_ex2_d;
    logic [1:0]       apply_mem_q, apply_mem_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic w_ex_hit_e, w_ex_hit_m, w_ex2_hit_e, w_ex2_hit_m;
    logic w_flush_eff, w_stall, w_load_bubble;

    fwd_reg_match u_match_ex (
        .src_a (dec_srcA),
        .src_b (dec_srcB),
        .entry (ex_q),
        .hit_e (w_ex_hit_e),
        .hit_m (w_ex_hit_m)
    );

    fwd_reg_match u_match_ex2 (
        .src_a (dec_srcA),
        .src_b (dec_srcB),
        .entry (ex2_q),
        .hit_e (w_ex2_hit_e),
        .hit_m (w_ex2_hit_m)
    );

    // Flush is only honoured while the pipe advances; the requester holds it through a freeze.
    assign w_flush_eff   = flush & ~hold;
    assign w_stall       = dec_valid & ~w_flush_eff & w_ex_hit_m;
    assign w_load_bubble = flush | w_stall | ~dec_valid;

    always_comb begin
        ex_d        = ex_q;
        ex2_d       = ex2_q;
        mem_d       = mem_q;
        apply_ex2_d = apply_ex2_q;
        apply_mem_d = apply_mem_q;
        stall_cnt_d = stall_cnt_q;
        if (!hold) begin
            mem_d = ex2_q;
            ex2_d = ex_q;
            if (w_load_bubble) begin
                ex_d        = ENTRY_EMPTY;
                apply_ex2_d = 1'b0;
                apply_mem_d = 2'b00;
            end else begin
                ex_d        = '{valid: 1'b1, dst_e: dec_dstE, dst_m: dec_dstM};
                apply_ex2_d = w_ex_hit_e;
                apply_mem_d = {w_ex2_hit_e, w_ex2_hit_m};
            end
            if (w_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_q        <= ENTRY_EMPTY;
            ex2_q       <= ENTRY_EMPTY;
            mem_q       <= ENTRY_EMPTY;
            apply_ex2_q <= 1'b0;
            apply_mem_q <= 2'b00;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            ex2_q       <= ex2_d;
            mem_q       <= mem_d;
            apply_ex2_q <= apply_ex2_d;
            apply_mem_q <= apply_mem_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_decode  = w_stall;
    assign ex_bubble     = ~ex_q.valid;
    assign fwd_apply_ex2 = apply_ex2_q;
    assign fwd_apply_mem = apply_mem_q;
    assign fwd_ex2_reg   = ex2_q.valid ? ex2_q.dst_e : RNONE;
    assign fwd_mem_regA  = mem_q.valid ? mem_q.dst_e : RNONE;
    assign fwd_mem_regB  = mem_q.valid ? mem_q.dst_m : RNONE;
    assign stall_count   = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fwd_hazard_ctrl.sv
// ============================================================================
//  Module   : tb_fwd_hazard_ctrl
//  Purpose  : Directed self-checking bench for fwd_hazard_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fwd_hazard_ctrl;

    localparam int          TB_CNT_W = 4;
    localparam logic [3:0]  F        = 4'hF;
    localparam logic [TB_CNT_W-1:0] CNT_MAX = {TB_CNT_W{1'b1}};

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       hold = 1'b0;
    logic       flush = 1'b0;
    logic       dec_valid = 1'b0;
    logic [3:0] dec_srcA = F, dec_srcB = F, dec_dstE = F, dec_dstM = F;
    logic       stall_decode, ex_bubble, fwd_apply_ex2;
    logic [1:0] fwd_apply_mem;
    logic [3:0] fwd_ex2_reg, fwd_mem_regA, fwd_mem_regB;
    logic [TB_CNT_W-1:0] stall_count;

    fwd_hazard_ctrl #(.CNT_W(TB_CNT_W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .hold          (hold),
        .flush         (flush),
        .dec_valid     (dec_valid),
        .dec_srcA      (dec_srcA),
        .dec_srcB      (dec_srcB),
        .dec_dstE      (dec_dstE),
        .dec_dstM      (dec_dstM),
        .stall_decode  (stall_decode),
        .ex_bubble     (ex_bubble),
        .fwd_apply_ex2 (fwd_apply_ex2),
        .fwd_apply_mem (fwd_apply_mem),
        .fwd_ex2_reg   (fwd_ex2_reg),
        .fwd_mem_regA  (fwd_mem_regA),
        .fwd_mem_regB  (fwd_mem_regB),
        .stall_count   (stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                bub;
        logic                ae2;
        logic [1:0]          am;
        logic [3:0]          r2;
        logic [3:0]          ra;
        logic [3:0]          rb;
        logic [TB_CNT_W-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    // Reference pipeline state
    logic       m_ex_v, m_ex2_v, m_mem_v;
    logic [3:0] m_ex_e, m_ex_m, m_ex2_e, m_ex2_m, m_mem_e, m_mem_m;
    logic       m_ae2;
    logic [1:0] m_am;
    logic [TB_CNT_W-1:0] m_cnt;

    function automatic logic mt(input logic [3:0] s, input logic [3:0] r, input logic v);
        return v && (r != F) && (s == r);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ex_v = 0; m_ex2_v = 0; m_mem_v = 0;
        m_ex_e = F; m_ex_m = F; m_ex2_e = F; m_ex2_m = F; m_mem_e = F; m_mem_m = F;
        m_ae2 = 0; m_am = 2'b00; m_cnt = '0;
    endtask

    task automatic reset_outputs_check(input string tag);
        chk({tag, "_bubble"}, ex_bubble, 1);
        chk({tag, "_ae2"},    fwd_apply_ex2, 0);
        chk({tag, "_am"},     fwd_apply_mem, 0);
        chk({tag, "_r2"},     fwd_ex2_reg, F);
        chk({tag, "_ra"},     fwd_mem_regA, F);
        chk({tag, "_rb"},     fwd_mem_regB, F);
        chk({tag, "_cnt"},    stall_count, 0);
        chk({tag, "_stall"},  stall_decode, 0);
    endtask

    // One clock: drive decode, check stall, predict and then check registered outputs.
    task automatic cyc(input logic dv, input logic [3:0] sa, input logic [3:0] sb,
                       input logic [3:0] de, input logic [3:0] dm,
                       input logic hd, input logic fl);
        exp_t e;
        logic st, bub;
        dec_valid = dv; dec_srcA = sa; dec_srcB = sb; dec_dstE = de; dec_dstM = dm;
        hold = hd; flush = fl;
        #3;
        st = dv && !(fl && !hd) && (mt(sa, m_ex_m, m_ex_v) || mt(sb, m_ex_m, m_ex_v));
        chk("stall_decode", stall_decode, st);
        if (!hd) begin
            bub = fl || st || !dv;
            if (bub) begin
                m_ae2 = 0; m_am = 2'b00;
            end else begin
                m_ae2   = mt(sa, m_ex_e, m_ex_v)   || mt(sb, m_ex_e, m_ex_v);
                m_am[1] = mt(sa, m_ex2_e, m_ex2_v) || mt(sb, m_ex2_e, m_ex2_v);
                m_am[0] = mt(sa, m_ex2_m, m_ex2_v) || mt(sb, m_ex2_m, m_ex2_v);
            end
            m_mem_v = m_ex2_v; m_mem_e = m_ex2_e; m_mem_m = m_ex2_m;
            m_ex2_v = m_ex_v;  m_ex2_e = m_ex_e;  m_ex2_m = m_ex_m;
            if (bub) begin
                m_ex_v = 0; m_ex_e = F; m_ex_m = F;
            end else begin
                m_ex_v = 1; m_ex_e = de; m_ex_m = dm;
            end
            if (st && m_cnt != CNT_MAX) m_cnt = m_cnt + 1'b1;
        end
        e.bub = !m_ex_v;
        e.ae2 = m_ae2;
        e.am  = m_am;
        e.r2  = m_ex2_v ? m_ex2_e : F;
        e.ra  = m_mem_v ? m_mem_e : F;
        e.rb  = m_mem_v ? m_mem_m : F;
        e.cnt = m_cnt;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("ex_bubble",     ex_bubble,     e.bub);
        chk("fwd_apply_ex2", fwd_apply_ex2, e.ae2);
        chk("fwd_apply_mem", fwd_apply_mem, e.am);
        chk("fwd_ex2_reg",   fwd_ex2_reg,   e.r2);
        chk("fwd_mem_regA",  fwd_mem_regA,  e.ra);
        chk("fwd_mem_regB",  fwd_mem_regB,  e.rb);
        chk("stall_count",   stall_count,   e.cnt);
    endtask

    task automatic nop();
        cyc(0, F, F, F, F, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        model_reset();
        #1 reset_n = 0;
        #1 reset_outputs_check("rst_init");
        @(posedge clk); #1;
        reset_n = 1;

        // ALU chain: I1 writes EAX, I2 reads it next, I3 reads it two behind
        cyc(1, F, F, 4'd0, F, 0, 0);
        cyc(1, 4'd0, F, F, F, 0, 0);
        chk("alu_ex2_flag", fwd_apply_ex2, 1);
        chk("alu_ex2_reg",  fwd_ex2_reg, 0);
        cyc(1, F, 4'd0, F, F, 0, 0);
        chk("alu_mem_flag", fwd_apply_mem, 2'b10);
        chk("alu_mem_regA", fwd_mem_regA, 0);
        nop(); nop(); nop();

        // Load-use: mrmovl into EDX, then addl EDX,ECX
        cyc(1, F, F, F, 4'd2, 0, 0);
        cyc(1, 4'd2, 4'd1, 4'd1, F, 0, 0);
        chk("ldu_bubble", ex_bubble, 1);
        cyc(1, 4'd2, 4'd1, 4'd1, F, 0, 0);
        chk("ldu_mem_flag", fwd_apply_mem, 2'b01);
        chk("ldu_mem_regB", fwd_mem_regB, 2);
        chk("ldu_count",    stall_count, 1);
        cyc(1, 4'd0, 4'd1, F, F, 0, 0);

        // Reset mid-traffic with a would-be hazard on decode
        cyc(1, F, F, F, 4'd6, 0, 0);
        dec_valid = 1; dec_srcA = 4'd6;
        reset_n = 0;
        #1 reset_outputs_check("rst_mid");
        model_reset();
        @(posedge clk); #1;
        reset_n = 1;
        nop();

        // popl: dstE=ESP, dstM=EBX; consumer reads EBX and ESP
        cyc(1, 4'd4, 4'd4, 4'd4, 4'd3, 0, 0);
        cyc(1, 4'd3, 4'd4, 4'd4, F, 0, 0);
        cyc(1, 4'd3, 4'd4, 4'd4, F, 0, 0);
        chk("pop_mem_flags", fwd_apply_mem, 2'b11);
        nop(); nop();

        // RNONE never matches
        cyc(1, F, F, F, F, 0, 0);
        cyc(1, F, F, F, F, 0, 0);
        cyc(1, F, F, F, F, 0, 0);
        chk("rnone_flags", {fwd_apply_ex2, fwd_apply_mem}, 3'b000);
        nop(); nop();

        // Hold during load-use, flush ignored while held, then flush after hold drops
        cyc(1, F, F, F, 4'd5, 0, 0);
        cyc(1, 4'd5, F, 4'd0, F, 1, 0);
        cyc(1, 4'd5, F, 4'd0, F, 1, 1);
        cyc(1, 4'd5, F, 4'd0, F, 1, 0);
        chk("hold_count", stall_count, 1);
        chk("hold_bubble", ex_bubble, 0);
        cyc(1, 4'd5, F, 4'd0, F, 0, 1);
        chk("flush_bubble", ex_bubble, 1);
        chk("flush_count", stall_count, 1);
        cyc(1, 4'd5, F, 4'd0, F, 0, 0);
        nop(); nop();

        // Counter saturation
        for (int i = 0; i < 20; i++) begin
            cyc(1, F, F, F, 4'd6, 0, 0);
            cyc(1, 4'd6, F, F, F, 0, 0);
        end
        chk("cnt_saturate", stall_count, CNT_MAX);
        nop();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
